// File: rtl/display_arbiter_if.sv
// Bus between the display requesters and the round-robin display arbiter.
// master = requester side, slave = arbiter side.
interface display_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0][15:0]  words;
  logic [NREQ-1:0]        grant;
  logic [2:0]             owner;
  logic [15:0]            word;
  logic                   blank;
  logic                   switched;

  modport master (
    output req, lock, words,
    input  grant, owner, word, blank, switched
  );

  modport slave (
    input  req, lock, words,
    output grant, owner, word, blank, switched
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin time-slice arbiter sharing one 4-digit hex display among NREQ
// requesters; every output is registered, no segment logic lives here.

// One requester lane: grant decode and word gating for the output OR-mux.
module display_arbiter_lane #(
  parameter int IDX = 0,
  parameter int IW  = 2
) (
  input  logic          show,
  input  logic [IW-1:0] sel,
  input  logic [15:0]   din,
  output logic          gnt,
  output logic [15:0]   dout
);
  assign gnt  = show && (sel == IW'(IDX));
  assign dout = gnt ? din : '0;
endmodule

module display_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 50_000_000,
  parameter int CW    = 26
) (
  input  logic              clk,
  input  logic              rst,
  display_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t                 state, state_n;
  logic [IW-1:0]          own, own_n;
  logic [IW-1:0]          last, last_n;
  logic [IW-1:0]          win, cand;
  logic                   found;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   sw_n, show_n;
  logic [NREQ-1:0]        gnt_n;
  logic [NREQ-1:0][15:0]  lane_word;
  logic [15:0]            word_n;

  logic [NREQ-1:0]        grant_q;
  logic [15:0]            word_q;
  logic                   blank_q, sw_q;

  // Search starts just past the last winner; in SHOW last==own, so the
  // current owner is examined last and only wins when it is alone.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    own_n   = own;
    last_n  = last;
    cnt_n   = cnt;
    sw_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = SHOW;
          own_n   = win;
          last_n  = win;
          cnt_n   = '0;
          sw_n    = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.req[own]) begin
          // Dropped owner releases at once, lock or not.
          sw_n  = 1'b1;
          cnt_n = '0;
          if (found) begin
            own_n  = win;
            last_n = win;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt == CW'(DWELL - 1)) begin
          if (!bus.lock[own]) begin
            own_n  = win;
            last_n = win;
            cnt_n  = '0;
            sw_n   = (win != own);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign show_n = (state_n == SHOW);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    display_arbiter_lane #(.IDX(i), .IW(IW)) u_lane (
      .show (show_n),
      .sel  (own_n),
      .din  (bus.words[i]),
      .gnt  (gnt_n[i]),
      .dout (lane_word[i])
    );
  end

  always_comb begin
    word_n = '0;
    for (int i = 0; i < NREQ; i++) word_n = word_n | lane_word[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      own     <= '0;
      last    <= IW'(NREQ - 1);
      cnt     <= '0;
      grant_q <= '0;
      word_q  <= '0;
      blank_q <= 1'b1;
      sw_q    <= 1'b0;
    end else begin
      state   <= state_n;
      own     <= own_n;
      last    <= last_n;
      cnt     <= cnt_n;
      grant_q <= gnt_n;
      word_q  <= word_n;
      blank_q <= !show_n;
      sw_q    <= sw_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = 3'(own);
  assign bus.word     = word_q;
  assign bus.blank    = blank_q;
  assign bus.switched = sw_q;
endmodule
